lock_code_driver: RTL and testbench



---
 rtl/lock_pkg.sv | 26 ++
 rtl/lock_timer.sv | 28 ++
 rtl/lock_code_driver.sv | 139 +++++++++++++
 tb/tb_lock_code_driver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock driver.
package lock_pkg;

  localparam int CODE_W = 6;

  // Bit positions of the lock inputs within a code word.
  localparam int A_BIT = 5;
  localparam int B_BIT = 4;
  localparam int C_BIT = 3;
  localparam int D_BIT = 2;
  localparam int E_BIT = 1;
  localparam int F_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RESULT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } lock_state_t;

  // Elaboration-time maximum, used to size the shared timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a zero flag. Shared between the code hold
// window and the lockout window, which never overlap in time.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority; decrement stops at zero so the flag stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_code_driver.sv
// Sequential initiator for the six-input combination lock: drives a latched
// code for a hold window, samples z, reports the result and enforces a timed
// lockout after too many consecutive failures.
//
// Handshake: an attempt is accepted on any rising edge where start=1 and
// busy=0 (IDLE). busy stays high until the attempt (and any lockout) is over;
// done pulses for exactly one cycle with unlocked valid in that same cycle.
// start while busy is dropped, never queued.
module lock_code_driver
  import lock_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [5:0]                     code_in,
  input  logic                           z_in,
  output logic [5:0]                     code_out,
  output logic                           busy,
  output logic                           done,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_count,
  output logic [1:0]                     state_dbg
);

  localparam int FC_W  = $clog2(MAX_TRIES + 1);
  // At least one bit even when both windows are a single cycle.
  localparam int TMR_W = $clog2(max_int(max_int(HOLD_CYCLES, LOCKOUT_CYCLES), 2));

  localparam logic [TMR_W-1:0] HOLD_LOAD    = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_MAX       = FC_W'(MAX_TRIES);

  lock_state_t      state, state_next;
  logic [5:0]       code_q, code_next;
  logic             unl_next;
  logic [FC_W-1:0]  fc_next;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic [TMR_W-1:0] tmr_count;
  logic             tmr_zero;

  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Next-state, latched-data and timer control decisions.
  always_comb begin
    state_next   = state;
    code_next    = code_q;
    unl_next     = unlocked;
    fc_next      = fail_count;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          code_next    = code_in;
          unl_next     = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LOAD;
          state_next   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (tmr_zero) begin
          unl_next   = z_in;
          state_next = ST_RESULT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RESULT: begin
        if (unlocked) begin
          fc_next    = '0;
          state_next = ST_IDLE;
        end else if ((int'(fail_count) + 1) < MAX_TRIES) begin
          fc_next    = fail_count + 1'b1;
          state_next = ST_IDLE;
        end else begin
          fc_next      = FC_MAX;
          tmr_load     = 1'b1;
          tmr_load_val = LOCKOUT_LOAD;
          state_next   = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_zero) begin
          fc_next    = '0;
          state_next = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and all outputs are registered; outputs decode the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      code_q     <= '0;
      code_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      fail_count <= '0;
    end else begin
      state      <= state_next;
      code_q     <= code_next;
      code_out   <= (state_next == ST_DRIVE) ? code_next : '0;
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_RESULT);
      unlocked   <= unl_next;
      locked_out <= (state_next == ST_LOCKOUT);
      fail_count <= fc_next;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_lock_code_driver.sv
// Bench for lock_code_driver with the combination lock in the loop.
module tb_lock_code_driver;
  import lock_pkg::*;

  localparam int HOLD  = 4;
  localparam int TRIES = 3;
  localparam int LOCK  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [5:0] code_in = '0;
  logic       z_in;
  logic [5:0] code_out;
  logic       busy, done, unlocked, locked_out;
  logic [1:0] fail_count;
  logic [1:0] state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int model_fail = 0;
  logic [2:0] exp_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  lock_code_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .code_in    (code_in),
    .z_in       (z_in),
    .code_out   (code_out),
    .busy       (busy),
    .done       (done),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_count (fail_count),
    .state_dbg  (state_dbg)
  );

  // The combination lock: opens when a or b is set and f is clear.
  assign z_in = (code_out[A_BIT] | code_out[B_BIT]) & ~code_out[F_BIT];

  // Reference model of the lock and of the attempt bookkeeping.
  function automatic logic lock_opens(input logic [5:0] c);
    return (c[5] | c[4]) & ~c[0];
  endfunction

  task automatic model_step(input logic [5:0] c, output bit e_lock);
    logic e_unl;
    e_unl = lock_opens(c);
    if (e_unl) model_fail = 0;
    else model_fail = model_fail + 1;
    e_lock = (model_fail == TRIES);
    exp_q.push_back({e_unl, 2'(model_fail)});
  endtask

  // Driver: one start pulse, then observe until one cycle after done.
  task automatic attempt(input logic [5:0] code, input logic [5:0] later_code,
                         input bit poke, output int done_at, output logic unl,
                         output logic [23:0] seen, output logic [1:0] fc_after,
                         output int dones);
    done_at = -1; unl = 1'bx; seen = '0; fc_after = 2'bxx; dones = 0;
    @(posedge clk); #1; start = 1'b1; code_in = code;
    @(posedge clk); #1; start = 1'b0; code_in = later_code;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= HOLD) seen = {seen[17:0], code_out};
      if (done) begin
        dones++;
        if (done_at < 0) begin done_at = k; unl = unlocked; end
      end
      if (poke && k == 2) start = 1'b1;
      if (poke && k == 3) start = 1'b0;
      if (done_at > 0 && k == done_at + 1) begin
        fc_after = fail_count;
        break;
      end
    end
  endtask

  // Driver: count lockout cycles from the current negedge, optionally poking start.
  task automatic wait_lockout(input bit poke, output int len, output int dones);
    len = 0; dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (!locked_out) break;
      len++;
      if (done) dones++;
      if (poke && len == 3) start = 1'b1;
      if (poke && len == 4) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run += 7;
    if (code_out !== 6'd0) begin tests_failed++; $display("FAIL reset_code_out got=%b exp=000000", code_out); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
    if (unlocked !== 1'b0) begin tests_failed++; $display("FAIL reset_unlocked got=%b exp=0", unlocked); end
    if (locked_out !== 1'b0) begin tests_failed++; $display("FAIL reset_locked_out got=%b exp=0", locked_out); end
    if (fail_count !== 2'd0) begin tests_failed++; $display("FAIL reset_fail_count got=%0d exp=0", fail_count); end
    if (state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    rst_n = 1'b1;
    model_fail = 0;
  endtask

  task automatic test_basic_unlock();
    int da, nd; logic u; logic [23:0] s; logic [1:0] fc; bit lk; logic [2:0] e;
    model_step(6'b101010, lk);
    attempt(6'b101010, 6'b101010, 1'b0, da, u, s, fc, nd);
    e = exp_q.pop_front();
    tests_run += 5;
    if (s !== {4{6'b101010}}) begin tests_failed++; $display("FAIL basic_code_out got=%h exp=%h", s, {4{6'b101010}}); end
    if (da !== HOLD + 1) begin tests_failed++; $display("FAIL basic_done_at got=%0d exp=%0d", da, HOLD + 1); end
    if (u !== e[2]) begin tests_failed++; $display("FAIL basic_unlocked got=%b exp=%b", u, e[2]); end
    if (fc !== e[1:0]) begin tests_failed++; $display("FAIL basic_fail_count got=%0d exp=%0d", fc, e[1:0]); end
    if (nd !== 1 || busy !== 1'b0) begin tests_failed++; $display("FAIL basic_single_done dones=%0d busy=%b exp 1/0", nd, busy); end
  endtask

  task automatic test_fail_then_unlock();
    int da, nd; logic u; logic [23:0] s; logic [1:0] fc; bit lk; logic [2:0] e;
    logic [5:0] codes [2];
    codes[0] = 6'b001010; codes[1] = 6'b011010;
    for (int i = 0; i < 2; i++) begin
      model_step(codes[i], lk);
      attempt(codes[i], codes[i], 1'b0, da, u, s, fc, nd);
      e = exp_q.pop_front();
      tests_run += 3;
      if (da !== HOLD + 1) begin tests_failed++; $display("FAIL fail_unlock_done_at[%0d] got=%0d exp=%0d", i, da, HOLD + 1); end
      if (u !== e[2]) begin tests_failed++; $display("FAIL fail_unlock_unlocked[%0d] got=%b exp=%b", i, u, e[2]); end
      if (fc !== e[1:0]) begin tests_failed++; $display("FAIL fail_unlock_fail_count[%0d] got=%0d exp=%0d", i, fc, e[1:0]); end
    end
  endtask

  task automatic test_lockout();
    int da, nd, len, ld; logic u; logic [23:0] s; logic [1:0] fc; bit lk; logic [2:0] e;
    for (int i = 0; i < TRIES; i++) begin
      model_step(6'b101011, lk);
      attempt(6'b101011, 6'b101011, (i == 1), da, u, s, fc, nd);
      e = exp_q.pop_front();
      tests_run += 3;
      if (u !== e[2] || da !== HOLD + 1) begin tests_failed++; $display("FAIL lockout_attempt[%0d] unlocked=%b done_at=%0d exp %b/%0d", i, u, da, e[2], HOLD + 1); end
      if (fc !== e[1:0]) begin tests_failed++; $display("FAIL lockout_fail_count[%0d] got=%0d exp=%0d", i, fc, e[1:0]); end
      if (nd !== 1 || s !== {4{6'b101011}}) begin tests_failed++; $display("FAIL lockout_start_ignored[%0d] dones=%0d code=%h", i, nd, s); end
    end
    wait_lockout(1'b1, len, ld);
    if (lk) model_fail = 0;
    tests_run += 3;
    if (len !== LOCK) begin tests_failed++; $display("FAIL lockout_length got=%0d exp=%0d", len, LOCK); end
    if (ld !== 0 || code_out !== 6'd0) begin tests_failed++; $display("FAIL lockout_quiet dones=%0d code_out=%b exp 0/0", ld, code_out); end
    @(negedge clk);
    if (fail_count !== 2'(model_fail) || busy !== 1'b0) begin tests_failed++; $display("FAIL lockout_exit fail_count=%0d busy=%b exp %0d/0", fail_count, busy, model_fail); end
  endtask

  task automatic test_code_change();
    int da, nd; logic u; logic [23:0] s; logic [1:0] fc; bit lk; logic [2:0] e;
    model_step(6'b111010, lk);
    attempt(6'b111010, 6'b000000, 1'b0, da, u, s, fc, nd);
    e = exp_q.pop_front();
    tests_run += 2;
    if (s !== {4{6'b111010}}) begin tests_failed++; $display("FAIL code_change_held got=%h exp=%h", s, {4{6'b111010}}); end
    if (u !== e[2] || fc !== e[1:0]) begin tests_failed++; $display("FAIL code_change_result unlocked=%b fc=%0d exp %b/%0d", u, fc, e[2], e[1:0]); end
  endtask

  task automatic test_back_to_back();
    int seen_at[$];
    int bad_unl = 0;
    @(posedge clk); #1; start = 1'b1; code_in = 6'b101010;
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (done) begin
        seen_at.push_back(k);
        if (unlocked !== 1'b1) bad_unl++;
      end
      if (k == 3 * (HOLD + 2) - 1) start = 1'b0;
    end
    tests_run += 2;
    if (seen_at.size() !== 3 || bad_unl !== 0) begin tests_failed++; $display("FAIL b2b_count got=%0d bad_unlocked=%0d exp 3/0", seen_at.size(), bad_unl); end
    for (int i = 0; i < seen_at.size() && i < 3; i++) begin
      if (seen_at[i] !== (HOLD + 1) + i * (HOLD + 2)) begin tests_failed++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, seen_at[i], (HOLD + 1) + i * (HOLD + 2)); end
    end
    model_fail = 0;
  endtask

  task automatic test_reset_in_lockout();
    int da, nd; logic u; logic [23:0] s; logic [1:0] fc; bit lk; logic [2:0] e;
    for (int i = 0; i < TRIES; i++) begin
      model_step(6'b001000, lk);
      attempt(6'b001000, 6'b001000, 1'b0, da, u, s, fc, nd);
      e = exp_q.pop_front();
    end
    repeat (4) @(negedge clk);
    tests_run += 2;
    if (locked_out !== 1'b1) begin tests_failed++; $display("FAIL rst_lockout_entered got=%b exp=1", locked_out); end
    #1; rst_n = 1'b0; #1;
    model_fail = 0;
    if (locked_out !== 1'b0 || fail_count !== 2'd0 || code_out !== 6'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async locked_out=%b fail_count=%0d code_out=%b busy=%b exp all 0", locked_out, fail_count, code_out, busy);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    model_step(6'b101010, lk);
    attempt(6'b101010, 6'b101010, 1'b0, da, u, s, fc, nd);
    e = exp_q.pop_front();
    tests_run++;
    if (da !== HOLD + 1 || u !== e[2] || fc !== e[1:0]) begin tests_failed++; $display("FAIL rst_restart done_at=%0d unlocked=%b fc=%0d exp %0d/%b/%0d", da, u, fc, HOLD + 1, e[2], e[1:0]); end
  endtask

  task automatic test_random();
    int da, nd, len, ld; logic u; logic [23:0] s; logic [1:0] fc; bit lk; logic [2:0] e;
    logic [5:0] c;
    for (int i = 0; i < 14; i++) begin
      c = 6'($urandom_range(0, 63));
      model_step(c, lk);
      attempt(c, 6'($urandom_range(0, 63)), 1'b0, da, u, s, fc, nd);
      e = exp_q.pop_front();
      tests_run++;
      if (da !== HOLD + 1 || u !== e[2] || fc !== e[1:0] || s !== {4{c}}) begin
        tests_failed++;
        $display("FAIL random[%0d] code=%b done_at=%0d unlocked=%b fc=%0d drv=%h exp %0d/%b/%0d", i, c, da, u, fc, s, HOLD + 1, e[2], e[1:0]);
      end
      if (lk) begin
        wait_lockout(1'b0, len, ld);
        model_fail = 0;
        tests_run++;
        if (len !== LOCK) begin tests_failed++; $display("FAIL random_lockout[%0d] len=%0d exp=%0d", i, len, LOCK); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_unlock();
    test_fail_then_unlock();
    test_lockout();
    test_code_change();
    test_back_to_back();
    test_reset_in_lockout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
